dmux_sched: RTL

Scheduler/arbiter that steers a single valid/ready input stream into two registered output channels, A and B. It owns the select decision for the two-way demux register datapath and adds per-channel handshaking and back-pressure. Steering follows a runtime-selectable policy: fixed A, fixed B, burst round-robin, or first-free. It sits between a producer and two consumer lanes that share one data source.

---
 rtl/dmux_sched_pkg.sv | 24 ++
 rtl/dmux_slot.sv | 40 ++++
 rtl/dmux_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/dmux_sched_pkg.sv
// Shared types for the two-way demux scheduler: steering policy, round-robin
// state and the burst counter width helper.
package dmux_sched_pkg;

  // Steering policy, encoded as driven on mode_i.
  typedef enum logic [1:0] {
    MODE_FIX_A = 2'd0,
    MODE_FIX_B = 2'd1,
    MODE_RR    = 2'd2,
    MODE_FREE  = 2'd3
  } mode_e;

  // Round-robin target state; the encoding doubles as the select value.
  typedef enum logic {
    ST_A = 1'b0,
    ST_B = 1'b1
  } rr_state_e;

  // Burst counter width; a one-word burst still needs a one-bit counter.
  function automatic int burst_cnt_w(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/dmux_slot.sv
// One-entry output register for a single demux lane: holds one word with a
// valid flag, loads on accept and clears on drain. A load that coincides
// with a drain keeps valid high, which is what sustains full throughput.
module dmux_slot
  import dmux_sched_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              free_o
);

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;

  // Output register: load wins over drain; data only moves on a load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (load_i) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_i;
    end else if (ready_i) begin
      vld_p1  <= 1'b0;
    end
  end

  assign valid_o = vld_p1;
  assign data_o  = data_p1;
  // The slot can take a word this cycle if empty or being drained now.
  assign free_o  = !vld_p1 || ready_i;

endmodule

// File: rtl/dmux_sched.sv
// Scheduler for a two-way valid/ready demux. Chooses the target lane from the
// runtime policy (fixed A, fixed B, burst round-robin, first-free), presents
// back-pressure to the producer and drives the two registered output lanes.
module dmux_sched
  import dmux_sched_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        mode_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              a_valid_o,
  input  logic              a_ready_i,
  output logic [DATA_W-1:0] a_data_o,
  output logic              b_valid_o,
  input  logic              b_ready_i,
  output logic [DATA_W-1:0] b_data_o,
  output logic              sel_o
);

  localparam int                CNT_W      = burst_cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  mode_e             mode_cur;
  mode_e             mode_q;
  rr_state_e         state_q;
  rr_state_e         state_d;
  logic [CNT_W-1:0]  burst_q;
  logic [CNT_W-1:0]  burst_d;
  logic              a_free;
  logic              b_free;
  logic              sel;
  logic              accept;
  logic              load_a;
  logic              load_b;

  // The new policy steers immediately; mode_q only detects the change.
  assign mode_cur = mode_e'(mode_i);

  // Target selection; first-free prefers A and parks on A when both are full.
  always_comb begin
    sel = 1'b0;
    unique case (mode_cur)
      MODE_FIX_A: sel = 1'b0;
      MODE_FIX_B: sel = 1'b1;
      MODE_RR:    sel = (state_q == ST_B);
      MODE_FREE:  sel = a_free ? 1'b0 : (b_free ? 1'b1 : 1'b0);
      default:    sel = 1'b0;
    endcase
  end

  // Ready depends only on the chosen slot, never on in_valid_i.
  assign in_ready_o = sel ? b_free : a_free;
  assign sel_o      = sel;
  assign accept     = in_valid_i && in_ready_o;
  assign load_a     = accept && !sel;
  assign load_b     = accept && sel;

  // Round-robin next state: mode change or non-RR mode parks on A with an
  // empty burst; otherwise each accept advances the burst and the last word
  // of a burst hands over to the other lane. A stalled lane is never skipped.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    if (mode_cur != mode_q || mode_cur != MODE_RR) begin
      state_d = ST_A;
      burst_d = '0;
    end else if (accept) begin
      if (burst_q == BURST_LAST) begin
        state_d = (state_q == ST_A) ? ST_B : ST_A;
        burst_d = '0;
      end else begin
        burst_d = burst_q + 1'b1;
      end
    end
  end

  // Control registers: policy history, round-robin state and burst count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q  <= MODE_FIX_A;
      state_q <= ST_A;
      burst_q <= '0;
    end else begin
      mode_q  <= mode_cur;
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  dmux_slot #(.DATA_W(DATA_W)) u_slot_a (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load_a),
    .data_i  (in_data_i),
    .ready_i (a_ready_i),
    .valid_o (a_valid_o),
    .data_o  (a_data_o),
    .free_o  (a_free)
  );

  dmux_slot #(.DATA_W(DATA_W)) u_slot_b (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load_b),
    .data_i  (in_data_i),
    .ready_i (b_ready_i),
    .valid_o (b_valid_o),
    .data_o  (b_data_o),
    .free_o  (b_free)
  );

endmodule
